usr_gen: RTL and testbench
==========================

Name: usr_gen

Overview:
Parametrised universal shift register, successor to the team's fixed-function 4-bit USR.
- Width-generic datapath.
- Dedicated serial in/out ports.
- Multi-bit barrel-style shifts and rotates by a runtime amount, plus arithmetic right shift.
- Self-timed serializer mode with busy/done handshake for driving serial links from a parallel word.

Parameters:
N, 8, register width in bits (N ≥ 2, power of two)
AW, 3, width of shift-amount input; must equal log2(N)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
en  input  1  clock enable; when 0, all state holds (serializer stalls)
ld  input  1  parallel load request (idle only)
mode  input  3  operation select (below)
amt  input  AW  shift/rotate amount, 0..N-1
sin  input  1  serial input bit
pin  input  N  parallel input word
start  input  1  serializer start request
pout  output  N  register contents
sout  output  1  serial output = pout[0] (combinational)
busy  output  1  serializer active
done  output  1  one-cycle pulse at serializer completion

Behaviour:
- Reset (rst=0, async): pout=0, busy=0, done=0, internal count=0. Takes effect immediately, including mid-serialization; no partial state survives.
- done defaults to 0 every cycle; it is high only in the cycle after serializer completion.
- en=0: pout, busy and count hold; done forced 0; start/ld/mode ignored.
- Idle (busy=0, en=1), priority start > ld > mode:
  - start=1: pout<=pin, busy<=1, count<=0.
  - ld=1: pout<=pin.
  - otherwise mode:
    - 000 hold.
    - 001 serial right: pout<={sin, pout[N-1:1]}.
    - 010 serial left: pout<={pout[N-2:0], sin}.
    - 011 logical right by amt, zero fill.
    - 100 logical left by amt, zero fill.
    - 101 arithmetic right by amt, MSB replicated.
    - 110 rotate left by amt.
    - 111 rotate right by amt.
  - amt=0 in modes 011–111 leaves pout unchanged.
  - Single-cycle latency for all operations: result visible the cycle after the edge.
- Serializer (busy=1, en=1):
  - Every edge: pout<={1'b0, pout[N-1:1]}, count<=count+1.
  - In busy cycle k (k=0..N-1), sout=pin[k] of the loaded word, LSB first.
  - On the edge where count==N-1: final shift, busy<=0, done<=1 next cycle; pout is then 0.
  - busy is high for exactly N enabled cycles.
  - start, ld, mode and sin are ignored while busy; start while busy is dropped, not queued.
  - start may be reasserted in the done cycle (busy=0) and begins a new word back-to-back.
- Count register width: log2(N)+1 bits; never exceeds N-1.

Optional Feature:
USR_GEN_PARITY_EN
- Defined: adds output port par (1 bit) = XOR-reduction of pout, combinational, 0 in reset.
- Undefined: par port and its logic are absent; all other behaviour identical.

Test Plan:
- Reset mid-op: start with pin=8'hA5, assert rst low after 3 busy cycles -> pout=0, busy=0, done=0 immediately; after release, idle hold.
- Load and shifts: ld pin=8'hB4 -> pout=8'hB4; then:
  - mode=101 amt=2 -> 8'hED.
  - reload 8'hB4, mode=011 amt=2 -> 8'h2D.
  - mode=100 amt=3 -> 8'h68.
- Rotates: load 8'h81.
  - mode=110 amt=1 -> 8'h03.
  - then mode=111 amt=4 -> 8'h30.
  - amt=0 -> 8'h30 held.
- Serial modes: from 0, mode=001 with sin=1 for 3 cycles -> 8'hE0. Then mode=010 with sin=0 for 2 cycles -> 8'h80.
- Serializer: start pin=8'h96 -> busy for 8 cycles, sout sequence 0,1,1,0,1,0,0,1, done pulse 1 cycle, pout=0. Also check:
  - en=0 for 2 mid-stream cycles extends busy to 10 cycles with sout held.
  - start/ld during busy ignored.
- Back-to-back: start 8'h01, reassert start with 8'hFF in done cycle -> second word begins with no idle gap. With USR_GEN_PARITY_EN, par=1 right after load of 8'h01.

Source files
------------

// File: rtl/usr_gen.sv
// rtl/usr_gen.sv - parametrised universal shift register with barrel shifts and self-timed serializer
// Optional feature macro: USR_GEN_PARITY_EN (adds output par = XOR of pout)
module usr_gen #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          ld,
    input  logic [2:0]    mode,
    input  logic [AW-1:0] amt,
    input  logic          sin,
    input  logic [N-1:0]  pin,
    input  logic          start,
    output logic [N-1:0]  pout,
    output logic          sout,
    output logic          busy,
    output logic          done
`ifdef USR_GEN_PARITY_EN
    ,
    output logic          par
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        SER  = 1'b1
    } state_t;

    // Last serializer cycle index; count runs 0..N-1 and never beyond.
    localparam logic [AW:0] LAST = (AW+1)'(N - 1);

    state_t       state, nxt_state;
    logic [AW:0]  cnt, nxt_cnt;
    logic [N-1:0] nxt_pout;
    logic         nxt_done;

    logic [N-1:0]   sra_res;
    logic [2*N-1:0] dbl_l, dbl_r;

    // Barrel helpers: doubling the word turns rotates into plain shifts.
    always_comb begin
        sra_res = N'($signed(pout) >>> amt);
        dbl_l   = {pout, pout} << amt;
        dbl_r   = {pout, pout} >> amt;
    end

    // Next-state and datapath selection; holds and done=0 are the defaults.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_pout  = pout;
        nxt_done  = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        nxt_pout  = pin;
                        nxt_cnt   = '0;
                        nxt_state = SER;
                    end else if (ld) begin
                        nxt_pout = pin;
                    end else begin
                        case (mode)
                            3'b000:  nxt_pout = pout;
                            3'b001:  nxt_pout = {sin, pout[N-1:1]};
                            3'b010:  nxt_pout = {pout[N-2:0], sin};
                            3'b011:  nxt_pout = pout >> amt;
                            3'b100:  nxt_pout = pout << amt;
                            3'b101:  nxt_pout = sra_res;
                            3'b110:  nxt_pout = dbl_l[2*N-1:N];
                            3'b111:  nxt_pout = dbl_r[N-1:0];
                            default: nxt_pout = pout;
                        endcase
                    end
                end
                SER: begin
                    nxt_pout = {1'b0, pout[N-1:1]};
                    if (cnt == LAST) begin
                        nxt_cnt   = '0;
                        nxt_state = IDLE;
                        nxt_done  = 1'b1;
                    end else begin
                        nxt_cnt = cnt + 1'b1;
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    // State register; reset clears everything immediately, even mid-word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            pout  <= '0;
            done  <= 1'b0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            pout  <= nxt_pout;
            done  <= nxt_done;
        end
    end

    assign busy = (state == SER);
    assign sout = pout[0];

`ifdef USR_GEN_PARITY_EN
    assign par = ^pout;
`endif

endmodule

// File: tb/tb_usr_gen.sv
// tb/tb_usr_gen.sv - self-checking bench for usr_gen against a behavioural model
module tb_usr_gen;

    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          ld = 1'b0;
    logic [2:0]    mode = 3'd0;
    logic [AW-1:0] amt = '0;
    logic          sin = 1'b0;
    logic [N-1:0]  pin = '0;
    logic          start = 1'b0;
    logic [N-1:0]  pout;
    logic          sout;
    logic          busy;
    logic          done;
`ifdef USR_GEN_PARITY_EN
    logic          par;
`endif

    usr_gen #(.N(N), .AW(AW)) dut (
        .clk(clk), .rst(rst), .en(en), .ld(ld), .mode(mode), .amt(amt),
        .sin(sin), .pin(pin), .start(start), .pout(pout), .sout(sout),
        .busy(busy), .done(done)
`ifdef USR_GEN_PARITY_EN
        , .par(par)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: word value, busy flag, bits already shifted out.
    int m_pout = 0;
    int m_word = 0;
    int m_k    = 0;
    bit m_busy = 1'b0;
    bit m_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pout = 0; m_word = 0; m_k = 0; m_busy = 1'b0; m_done = 1'b0;
    endtask

    // One rising edge as the specification describes it, in plain arithmetic.
    task automatic model_edge();
        int s;
        if (!rst) begin
            model_reset();
            return;
        end
        m_done = 1'b0;
        if (!en) return;
        if (m_busy) begin
            m_k++;
            m_pout = m_word / (2 ** m_k);
            if (m_k == N) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else if (start) begin
            m_word = int'(pin); m_pout = int'(pin); m_busy = 1'b1; m_k = 0;
        end else if (ld) begin
            m_pout = int'(pin);
        end else begin
            case (mode)
                3'd1: m_pout = (m_pout / 2) + (sin ? 2 ** (N - 1) : 0);
                3'd2: m_pout = ((m_pout * 2) % (2 ** N)) + int'(sin);
                3'd3: m_pout = m_pout / (2 ** amt);
                3'd4: m_pout = (m_pout * (2 ** amt)) % (2 ** N);
                3'd5: begin
                    s = (m_pout >= 2 ** (N - 1)) ? m_pout - 2 ** N : m_pout;
                    s = s >>> amt;
                    m_pout = s & (2 ** N - 1);
                end
                3'd6: repeat (int'(amt)) m_pout = ((m_pout * 2) % (2 ** N)) + m_pout / (2 ** (N - 1));
                3'd7: repeat (int'(amt)) m_pout = (m_pout / 2) + (m_pout % 2) * (2 ** (N - 1));
                default: ;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pout"}, 32'(pout), 32'(m_pout));
        chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
        chk({tag, ".done"}, 32'(done), 32'(m_done));
        chk({tag, ".sout"}, 32'(sout), 32'(m_pout % 2));
`ifdef USR_GEN_PARITY_EN
        chk({tag, ".par"}, 32'(par), 32'($countones(m_pout) % 2));
`endif
    endtask

    task automatic step(input string tag, input logic e, input logic l, input logic [2:0] md,
                        input logic [AW-1:0] a, input logic si, input logic [N-1:0] p,
                        input logic st);
        en = e; ld = l; mode = md; amt = a; sin = si; pin = p; start = st;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b1, 1'b0, 3'd0, '0, 1'b0, '0, 1'b0);
    endtask

    logic [N-1:0] sbits;
    int           sidx;
    int           bcnt;
    logic         e_i;

    initial begin
        // Reset state
        #1;
        chk("rst.pout", 32'(pout), 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);
        chk("rst.done", 32'(done), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle("rst_rel");

        // Reset mid-serialization
        step("a5_start", 1'b1, 1'b0, 3'd0, '0, 1'b0, 8'hA5, 1'b1);
        idle("a5_b1"); idle("a5_b2");
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("midrst.pout", 32'(pout), 32'h0);
        chk("midrst.busy", 32'(busy), 32'h0);
        chk("midrst.done", 32'(done), 32'h0);
        step("in_rst", 1'b1, 1'b0, 3'd0, '0, 1'b0, 8'hFF, 1'b1);
        #1 rst = 1'b1;
        idle("post_rst_hold");
        chk("post_rst.pout", 32'(pout), 32'h0);

        // Load and shifts
        step("ld_b4", 1'b1, 1'b1, 3'd0, '0, 1'b0, 8'hB4, 1'b0);
        chk("ld_b4.k", 32'(pout), 32'hB4);
        step("sra2", 1'b1, 1'b0, 3'd5, 3'd2, 1'b0, '0, 1'b0);
        chk("sra2.k", 32'(pout), 32'hED);
        step("ld_b4b", 1'b1, 1'b1, 3'd0, '0, 1'b0, 8'hB4, 1'b0);
        step("srl2", 1'b1, 1'b0, 3'd3, 3'd2, 1'b0, '0, 1'b0);
        chk("srl2.k", 32'(pout), 32'h2D);
        step("sll3", 1'b1, 1'b0, 3'd4, 3'd3, 1'b0, '0, 1'b0);
        chk("sll3.k", 32'(pout), 32'h68);

        // Rotates
        step("ld_81", 1'b1, 1'b1, 3'd0, '0, 1'b0, 8'h81, 1'b0);
        step("rol1", 1'b1, 1'b0, 3'd6, 3'd1, 1'b0, '0, 1'b0);
        chk("rol1.k", 32'(pout), 32'h03);
        step("ror4", 1'b1, 1'b0, 3'd7, 3'd4, 1'b0, '0, 1'b0);
        chk("ror4.k", 32'(pout), 32'h30);
        step("ror0", 1'b1, 1'b0, 3'd7, 3'd0, 1'b0, '0, 1'b0);
        chk("ror0.k", 32'(pout), 32'h30);

        // Serial modes
        step("ld_00", 1'b1, 1'b1, 3'd0, '0, 1'b0, 8'h00, 1'b0);
        repeat (3) step("sr1", 1'b1, 1'b0, 3'd1, '0, 1'b1, '0, 1'b0);
        chk("sr3.k", 32'(pout), 32'hE0);
        repeat (2) step("sl0", 1'b1, 1'b0, 3'd2, '0, 1'b0, '0, 1'b0);
        chk("sl2.k", 32'(pout), 32'h80);

        // Serializer with two stalled cycles and ignored start/ld while busy
        step("s96", 1'b1, 1'b0, 3'd0, '0, 1'b0, 8'h96, 1'b1);
        sbits = '0; sidx = 0; bcnt = 1;
        for (int i = 0; i < 20 && busy; i++) begin
            e_i = !(i == 3 || i == 4);
            if (e_i && sidx < N) begin
                sbits[sidx] = sout;
                sidx++;
            end
            step("s96_run", e_i, 1'b1, 3'd4, 3'd1, 1'b1, 8'h00, 1'b1);
            if (busy) bcnt++;
        end
        chk("s96.sout_seq", 32'(sbits), 32'h96);
        chk("s96.busy_len", 32'(bcnt), 32'd10);
        chk("s96.done", 32'(done), 32'h1);
        chk("s96.pout0", 32'(pout), 32'h0);
        idle("s96_after");
        chk("s96.done_pulse", 32'(done), 32'h0);

        // Back-to-back words
        step("b2b_01", 1'b1, 1'b0, 3'd0, '0, 1'b0, 8'h01, 1'b1);
`ifdef USR_GEN_PARITY_EN
        chk("b2b_01.par", 32'(par), 32'h1);
`endif
        for (int i = 0; i < 12 && !done; i++) idle("b2b_run");
        chk("b2b.done_seen", 32'(done), 32'h1);
        step("b2b_ff", 1'b1, 1'b0, 3'd0, '0, 1'b0, 8'hFF, 1'b1);
        chk("b2b_ff.busy", 32'(busy), 32'h1);
        chk("b2b_ff.pout", 32'(pout), 32'hFF);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rnd", ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) == 0),
                 3'($urandom), AW'($urandom), 1'($urandom), N'($urandom),
                 1'($urandom_range(0, 11) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
